intr_ack_sequencer: RTL and testbench
=====================================

// Module: intr_ack_sequencer
// PURPOSE
//  CPU-side initiator of the interrupt-acknowledge protocol answered by the 8259 PIC.
//  Samples the PIC's INT output and, at an instruction boundary with interrupts enabled, runs the two-pulse INTA# bus sequence.
//  Captures the vector byte the PIC drives during the second pulse and hands it to the CPU core through a valid/ack handshake.
//  Sits between the 8259 pins and the 8088 core's interrupt entry logic.
// PARAMETERS
//  PULSE_LEN  2  clocks inta_n is held low per acknowledge pulse (>=1)
//  GAP_LEN    2  clocks inta_n is held high between the two pulses (>=1)
//  CNT_W      3  width of the pulse/gap counter; must hold max(PULSE_LEN,GAP_LEN)-1
// PORTS
//  clk          in   1  system clock; all state changes on its rising edge
//  reset        in   1  synchronous, active-high reset
//  intr         in   1  interrupt request from PIC (asynchronous to clk)
//  if_en        in   1  CPU interrupt-enable flag
//  boundary     in   1  core is at an instruction boundary this cycle
//  d_in         in   8  data bus as driven by the PIC
//  inta_n       out  1  interrupt acknowledge strobe to PIC, active low
//  lock_n       out  1  bus lock, low for the whole two-pulse sequence
//  busy         out  1  high whenever the state is not IDLE
//  vector       out  8  captured interrupt vector number
//  vector_valid out  1  vector holds a fresh value
//  vector_ack   in   1  core has consumed vector
// BEHAVIOUR
//  Reset: state=IDLE; inta_n=1, lock_n=1, busy=0, vector=8'h00, vector_valid=0; sync flops cleared.
//  Reset mid-sequence wins: next cycle is IDLE and inta_n/lock_n return high immediately, with no partial pulse.
//  intr passes a 2-flop synchronizer (intr_s); raw intr is never used by the FSM.
//  States: IDLE, ACK1, GAP, ACK2, DONE. cnt is loaded on state entry; the state exits when cnt==0.
//   IDLE: leaves when intr_s & if_en & boundary are high in the same cycle -> ACK1, cnt<=PULSE_LEN-1.
//   ACK1: inta_n=0 for PULSE_LEN cycles -> GAP, cnt<=GAP_LEN-1.
//   GAP:  inta_n=1 for GAP_LEN cycles -> ACK2, cnt<=PULSE_LEN-1.
//   ACK2: inta_n=0 for PULSE_LEN cycles. On the final ACK2 cycle (cnt==0), vector<=d_in; then -> DONE.
//   DONE: vector_valid=1, held until vector_ack is sampled high -> IDLE. vector_ack is ignored outside DONE.
//  Outputs:
//   inta_n and lock_n are registered; they change on the clock edge that enters the state.
//   lock_n=0 in ACK1, GAP and ACK2, and 1 otherwise.
//   busy is 1 in every state except IDLE.
//   vector holds its value until the next capture.
//  Latency:
//   Acceptance edge to first inta_n low: 1 clock.
//   Acceptance to vector_valid high: 2*PULSE_LEN+GAP_LEN clocks.
//   Minimum restart: the first IDLE cycle after ack may accept again.
//  Boundary cases:
//   intr_s dropping after ACK1 has begun does not abort; the sequence completes and captures whatever the PIC drives (its spurious vector).
//   intr_s high while if_en=0 or boundary=0: stay in IDLE, no pulses.
//   vector_ack high in the same cycle DONE is entered: the ack is taken; vector_valid is high for exactly 1 cycle.
//   intr_s still high after DONE->IDLE: a new sequence starts if the accept conditions hold.
// STRUCTURE
//  Shared include intr_pkg.vh:
//   state encodings ST_IDLE=0, ST_ACK1=1, ST_GAP=2, ST_ACK2=3, ST_DONE=4 (3 bits);
//   default PULSE_LEN/GAP_LEN constants.
//  Sub-module sync_2ff (1-bit, 2-flop synchronizer with synchronous reset), instantiated for intr.
//  Body: one FSM register block, one counter, one vector capture register, registered outputs.
// TESTING
//  1. Defaults; intr=1, if_en=1, boundary pulsed 1 cycle after sync
//     -> inta_n low 2, high 2, low 2 clocks;
//     -> d_in=8'h08 during ACK2 gives vector=8'h08, vector_valid 6 clocks after accept.
//  2. intr=1, if_en=0 for 20 cycles -> inta_n, lock_n stay 1, busy=0;
//     raise if_en with boundary -> sequence starts next edge.
//  3. Drop intr during GAP; d_in=8'h0F in ACK2 -> sequence completes, vector=8'h0F (spurious IR7 path).
//  4. Assert reset during ACK2 -> next cycle inta_n=1, lock_n=1, busy=0, vector_valid=0, vector=8'h00.
//  5. Hold vector_ack=0 for 10 cycles in DONE -> vector_valid stays 1, no new pulses despite intr=1;
//     ack -> IDLE, then restart.
//  6. PULSE_LEN=1, GAP_LEN=3 -> inta_n pattern 0,1,1,1,0; lock_n low 5 consecutive clocks.

Source files
------------

// File: rtl/intr_ack_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intr_ack_sequencer_pkg
// Description : Shared state encodings, default timing constants and output
//               decode helpers for the 8259 interrupt-acknowledge sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package intr_ack_sequencer_pkg;

    // Sequencer states; encodings are fixed so they match external tooling.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACK1 = 3'd1,
        ST_GAP  = 3'd2,
        ST_ACK2 = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Default timing: clocks per INTA# pulse, clocks between pulses, counter width.
    localparam int DEF_PULSE_LEN = 2;
    localparam int DEF_GAP_LEN   = 2;
    localparam int DEF_CNT_W     = 3;

    // INTA# is driven low only while one of the two acknowledge pulses is active.
    function automatic logic is_pulse(input state_t s);
        return (s == ST_ACK1) || (s == ST_ACK2);
    endfunction

    // LOCK# covers the whole two-pulse window, including the gap.
    function automatic logic is_locked(input state_t s);
        return (s == ST_ACK1) || (s == ST_GAP) || (s == ST_ACK2);
    endfunction

endpackage : intr_ack_sequencer_pkg
`default_nettype wire

// File: rtl/intr_ack_sequencer_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : intr_ack_sequencer_sync_2ff
// Description : 1-bit two-flop synchronizer with synchronous active-high
//               reset, used to bring the PIC INT pin into the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module intr_ack_sequencer_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : intr_ack_sequencer_sync_2ff
`default_nettype wire

// File: rtl/intr_ack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : intr_ack_sequencer
// Description : CPU-side initiator of the 8259 interrupt-acknowledge cycle.
//               Accepts a synchronized INT at an instruction boundary with
//               interrupts enabled, issues two INTA# pulses under LOCK#,
//               captures the vector byte on the second pulse and offers it
//               to the core through a valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module intr_ack_sequencer
    import intr_ack_sequencer_pkg::*;
#(
    parameter int PULSE_LEN = DEF_PULSE_LEN,
    parameter int GAP_LEN   = DEF_GAP_LEN,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       intr_i,
    input  logic       if_en_i,
    input  logic       boundary_i,
    input  logic [7:0] d_in_i,
    output logic       inta_n_o,
    output logic       lock_n_o,
    output logic       busy_o,
    output logic [7:0] vector_o,
    output logic       vector_valid_o,
    input  logic       vector_ack_i
);

    // Counter reload values: a state lasting N clocks starts its count at N-1.
    localparam logic [CNT_W-1:0] C_PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] C_GAP_LOAD   = CNT_W'(GAP_LEN - 1);

    logic             intr_s;
    logic             w_accept;
    logic             w_cnt_zero;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       vector_q;
    logic [7:0]       vector_d;
    logic             inta_n_q;
    logic             lock_n_q;
    logic             busy_q;
    logic             valid_q;

    // INT is asynchronous to clk; only the synchronized copy reaches the FSM.
    intr_ack_sequencer_sync_2ff u_intr_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (intr_i),
        .q_o   (intr_s)
    );

    assign w_accept   = intr_s & if_en_i & boundary_i;
    assign w_cnt_zero = (cnt_q == '0);

    // Next-state, counter reload and vector capture decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = w_cnt_zero ? cnt_q : (cnt_q - CNT_W'(1));
        vector_d = vector_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d = ST_ACK1;
                    cnt_d   = C_PULSE_LOAD;
                end
            end
            ST_ACK1: begin
                if (w_cnt_zero) begin
                    state_d = ST_GAP;
                    cnt_d   = C_GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (w_cnt_zero) begin
                    state_d = ST_ACK2;
                    cnt_d   = C_PULSE_LOAD;
                end
            end
            ST_ACK2: begin
                // The PIC has had the whole pulse to settle the bus; sample on its last clock.
                if (w_cnt_zero) begin
                    state_d  = ST_DONE;
                    cnt_d    = '0;
                    vector_d = d_in_i;
                end
            end
            ST_DONE: begin
                if (vector_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pulse/gap duration counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Vector capture register; holds until the next second-pulse capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            vector_q <= 8'h00;
        end else begin
            vector_q <= vector_d;
        end
    end

    // Outputs decoded from the next state so they switch on the edge entering that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            inta_n_q <= 1'b1;
            lock_n_q <= 1'b1;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            inta_n_q <= ~is_pulse(state_d);
            lock_n_q <= ~is_locked(state_d);
            busy_q   <= (state_d != ST_IDLE);
            valid_q  <= (state_d == ST_DONE);
        end
    end

    assign inta_n_o       = inta_n_q;
    assign lock_n_o       = lock_n_q;
    assign busy_o         = busy_q;
    assign vector_o       = vector_q;
    assign vector_valid_o = valid_q;

endmodule : intr_ack_sequencer
`default_nettype wire

// File: tb/tb_intr_ack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_intr_ack_sequencer
// Description : Self-checking bench for intr_ack_sequencer. Directed vectors
//               drive a default-timing instance (A) and a PULSE_LEN=1,
//               GAP_LEN=3 instance (B); captured vectors are checked by a
//               scoreboard monitor decoupled from the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intr_ack_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       intr;
    logic       if_en_a;
    logic       if_en_b;
    logic       boundary;
    logic [7:0] d_in;
    logic       vector_ack;

    logic       inta_a, lock_a, busy_a, valid_a;
    logic [7:0] vec_a;
    logic       inta_b, lock_b, busy_b, valid_b;
    logic [7:0] vec_b;

    logic       sel = 1'b0;
    logic       w_inta, w_lock, w_busy, w_valid;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic       prev_valid_a = 1'b0;
    logic       prev_valid_b = 1'b0;

    always #5 clk = ~clk;

    assign w_inta  = sel ? inta_b  : inta_a;
    assign w_lock  = sel ? lock_b  : lock_a;
    assign w_busy  = sel ? busy_b  : busy_a;
    assign w_valid = sel ? valid_b : valid_a;

    intr_ack_sequencer u_dut_a (
        .clk            (clk),
        .reset          (reset),
        .intr_i         (intr),
        .if_en_i        (if_en_a),
        .boundary_i     (boundary),
        .d_in_i         (d_in),
        .inta_n_o       (inta_a),
        .lock_n_o       (lock_a),
        .busy_o         (busy_a),
        .vector_o       (vec_a),
        .vector_valid_o (valid_a),
        .vector_ack_i   (vector_ack)
    );

    intr_ack_sequencer #(
        .PULSE_LEN (1),
        .GAP_LEN   (3),
        .CNT_W     (3)
    ) u_dut_b (
        .clk            (clk),
        .reset          (reset),
        .intr_i         (intr),
        .if_en_i        (if_en_b),
        .boundary_i     (boundary),
        .d_in_i         (d_in),
        .inta_n_o       (inta_b),
        .lock_n_o       (lock_b),
        .busy_o         (busy_b),
        .vector_o       (vec_b),
        .vector_valid_o (valid_b),
        .vector_ack_i   (vector_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One acknowledge sequence on the selected instance. Entered #1 after an
    // edge with intr_s already high and if_en set; boundary is pulsed here.
    task automatic run_seq(input logic [7:0] vec, input logic [7:0] exp_pat,
                           input int len, input bit drop, input bit hold);
        logic [7:0] pat_inta;
        logic [7:0] pat_lock;
        logic [7:0] exp_lock;
        pat_inta = 8'h00;
        pat_lock = 8'hFF;
        exp_lock = 8'hFF;
        exp_lock = exp_lock << len;
        d_in     = vec;
        if (sel) qb.push_back(vec);
        else     qa.push_back(vec);
        boundary = 1'b1;
        step(1);
        boundary = 1'b0;
        for (int k = 0; k < len; k++) begin
            pat_inta[k] = w_inta;
            pat_lock[k] = w_lock;
            if (drop && k == 2) intr = 1'b0;
            step(1);
        end
        check("inta_pattern", pat_inta, exp_pat);
        check("lock_pattern", pat_lock, exp_lock);
        check("valid_latency", w_valid, 1'b1);
        check("done_inta_high", w_inta, 1'b1);
        check("done_lock_high", w_lock, 1'b1);
        check("done_busy", w_busy, 1'b1);
        if (!hold) begin
            vector_ack = 1'b1;
            step(1);
            vector_ack = 1'b0;
            check("valid_one_cycle", w_valid, 1'b0);
            check("idle_after_ack", w_busy, 1'b0);
        end
    endtask

    // Scoreboard monitor: each new vector_valid pops and compares one entry.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (valid_a && !prev_valid_a) begin
                if (qa.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_a_unexpected: got vector %0h expected none", vec_a);
                end else begin
                    check("vector_a", vec_a, qa.pop_front());
                end
            end
            if (valid_b && !prev_valid_b) begin
                if (qb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_b_unexpected: got vector %0h expected none", vec_b);
                end else begin
                    check("vector_b", vec_b, qb.pop_front());
                end
            end
            prev_valid_a = valid_a;
            prev_valid_b = valid_b;
        end
    end

    initial begin
        logic ok;
        reset      = 1'b1;
        intr       = 1'b0;
        if_en_a    = 1'b0;
        if_en_b    = 1'b0;
        boundary   = 1'b0;
        d_in       = 8'h00;
        vector_ack = 1'b0;
        step(3);
        check("rst_inta", inta_a, 1'b1);
        check("rst_lock", lock_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_valid", valid_a, 1'b0);
        check("rst_vector", vec_a, 8'h00);
        reset = 1'b0;
        step(1);

        // 1: default timing, vector 08h.
        intr    = 1'b1;
        if_en_a = 1'b1;
        step(3);
        sel = 1'b0;
        run_seq(8'h08, 8'b0000_1100, 6, 1'b0, 1'b0);

        // intr_s high with boundary low: stays idle.
        step(3);
        check("no_boundary_idle", busy_a, 1'b0);

        // 2: interrupts disabled for 20 cycles, then enabled with boundary.
        if_en_a = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            boundary = i[0];
            step(1);
            if (inta_a !== 1'b1 || lock_a !== 1'b1 || busy_a !== 1'b0) ok = 1'b0;
        end
        boundary = 1'b0;
        check("if_en0_idle", ok, 1'b1);
        if_en_a = 1'b1;
        run_seq(8'h42, 8'b0000_1100, 6, 1'b0, 1'b0);

        // 3: intr drops during GAP; spurious vector still captured.
        run_seq(8'h0F, 8'b0000_1100, 6, 1'b1, 1'b0);
        step(3);
        boundary = 1'b1;
        step(1);
        boundary = 1'b0;
        check("no_start_intr_low", busy_a, 1'b0);

        // 4: reset during ACK2.
        intr = 1'b1;
        step(3);
        boundary = 1'b1;
        step(1);
        boundary = 1'b0;
        step(4);
        check("in_ack2_inta_low", inta_a, 1'b0);
        reset = 1'b1;
        step(1);
        check("midrst_inta", inta_a, 1'b1);
        check("midrst_lock", lock_a, 1'b1);
        check("midrst_busy", busy_a, 1'b0);
        check("midrst_valid", valid_a, 1'b0);
        check("midrst_vector", vec_a, 8'h00);
        reset = 1'b0;

        // 5: hold ack low in DONE, then ack and restart in the first IDLE cycle.
        step(3);
        run_seq(8'h5A, 8'b0000_1100, 6, 1'b0, 1'b1);
        boundary = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (valid_a !== 1'b1 || inta_a !== 1'b1 || busy_a !== 1'b1) ok = 1'b0;
        end
        check("done_hold", ok, 1'b1);
        check("held_vector", vec_a, 8'h5A);
        boundary   = 1'b0;
        vector_ack = 1'b1;
        step(1);
        vector_ack = 1'b0;
        check("ack_to_idle", busy_a, 1'b0);
        run_seq(8'hA5, 8'b0000_1100, 6, 1'b0, 1'b0);

        // 6: PULSE_LEN=1, GAP_LEN=3 instance.
        if_en_a = 1'b0;
        if_en_b = 1'b1;
        sel     = 1'b1;
        check("b_lock_before", lock_b, 1'b1);
        run_seq(8'h77, 8'b0000_1110, 5, 1'b0, 1'b0);
        if_en_b = 1'b0;
        sel     = 1'b0;

        step(3);
        check("sb_a_drained", qa.size(), 0);
        check("sb_b_drained", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_intr_ack_sequencer
`default_nettype wire
